// File: rtl/wb_spi_ctrl_pkg.sv
// Shared definitions for the Wishbone SPI master: register offsets, STATUS bit
// positions and the shift-engine state encoding.
package wb_spi_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CS     = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/wb_spi_ctrl_if.sv
// Classic Wishbone slave bundle for the SPI controller.
// Handshake: a request is valid while cyc & stb are high; the slave accepts it by
// raising ack for exactly one cycle, and read data is valid only while ack is high.
interface wb_spi_ctrl_if;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_ctrl_shift_engine.sv
// SPI mode-0 byte shifter: divider, bit counter, shift register and MISO sample flop.
// A start pulse in IDLE latches tx and div; done_pulse marks the IDLE-return edge.
module spi_shift_engine
  import wb_spi_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] rx,
  output logic       sck,
  output logic       mosi,
  output spi_state_e state_dbg
);

  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] div_q, div_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] bit_q, bit_d;
  logic       sample_q, sample_d;
  logic       sck_q;
  logic       half_done;

  // The counter never passes div_q, so DIV=255 yields 256 cycles without wrapping.
  assign half_done = (cnt_q == div_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    div_d      = div_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    sample_d   = sample_q;
    done_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          shift_d = tx;
          div_d   = div;
          bit_d   = 3'd0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (half_done) begin
          cnt_d    = 8'd0;
          sample_d = miso;
          state_d  = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (half_done) begin
          cnt_d   = 8'd0;
          shift_d = {shift_q[6:0], sample_q};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_d       = {shift_q[6:0], sample_q};
            done_pulse = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      shift_q  <= 8'd0;
      div_q    <= 8'd0;
      rx_q     <= 8'd0;
      bit_q    <= 3'd0;
      sample_q <= 1'b0;
      sck_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      sck_q    <= (state_d == ST_HIGH);
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rx        = rx_q;
  assign sck       = sck_q;
  assign mosi      = shift_q[7];
  assign state_dbg = state_q;

endmodule

// File: rtl/wb_spi_ctrl.sv
// Wishbone register block for the SPI master: DATA/STATUS/CS/DIV decode, sticky DONE,
// chip selects, and the byte shift engine.
module wb_spi_ctrl
  import wb_spi_ctrl_pkg::*;
#(
  parameter int         NUM_CS    = 1,
  parameter logic [7:0] DIV_RESET = 8'd0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  wb_spi_ctrl_if.slave      wb,
  output logic              spi_sck_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_n_o,
  output spi_state_e        state_dbg
);

  logic [1:0]        reg_sel;
  logic              access, wr_en, rd_en, start;
  logic              busy, done_pulse, done_q;
  logic [7:0]        rx, div_q;
  logic [NUM_CS-1:0] cs_q;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign reg_sel = wb.wb_adr_i[3:2];
  assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr_en   = access & wb.wb_we_i & wb.wb_sel_i[0];
  assign rd_en   = access & ~wb.wb_we_i;
  // A DATA write while a byte is in flight is acknowledged but never reaches the engine.
  assign start   = wr_en & (reg_sel == REG_DATA) & ~busy;

  assign unused_bits = &{1'b0, wb.wb_adr_i[1:0], wb.wb_dat_i[31:8], wb.wb_sel_i[3:1]};

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data[7:0] = rx;
      REG_STATUS: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done_q;
      end
      REG_CS:     rd_data[NUM_CS-1:0] = cs_q;
      REG_DIV:    rd_data[7:0] = div_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 32'd0;
      done_q      <= 1'b0;
      cs_q        <= '0;
      div_q       <= DIV_RESET;
    end else begin
      wb.wb_ack_o <= access;
      wb.wb_dat_o <= rd_en ? rd_data : 32'd0;
      if (wr_en && reg_sel == REG_CS)  cs_q  <= wb.wb_dat_i[NUM_CS-1:0];
      if (wr_en && reg_sel == REG_DIV) div_q <= wb.wb_dat_i[7:0];
      // Completion wins over a coincident DATA read so a finished byte is never missed.
      if (done_pulse)
        done_q <= 1'b1;
      else if (start || (rd_en && reg_sel == REG_DATA))
        done_q <= 1'b0;
    end
  end

  spi_shift_engine u_engine (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .start      (start),
    .tx         (wb.wb_dat_i[7:0]),
    .div        (div_q),
    .miso       (spi_miso_i),
    .busy       (busy),
    .done_pulse (done_pulse),
    .rx         (rx),
    .sck        (spi_sck_o),
    .mosi       (spi_mosi_o),
    .state_dbg  (state_dbg)
  );

  assign spi_cs_n_o = ~cs_q;

endmodule
